// File: rtl/aes_result_collector.sv
// -----------------------------------------------------------------------------
// aes_result_collector
//
// Consumer end of the aes_engine output interface. Every cycle the engine is
// not halted, the engine's out/out_type pair is sampled. Completed ENCRYPT and
// DECRYPT results are written into a circular FIFO and the oldest one is
// offered downstream on a valid/ready handshake. The registered halt output
// back-pressures the engine so that no result is lost or sampled twice.
//
// Optional feature (macro AES_COLLECT_STATS_EN):
//   When defined, adds saturating 32-bit counters enc_cnt / dec_cnt that count
//   accepted ENCRYPT / DECRYPT results. They are cleared by rst only, not by
//   flush. When undefined, the ports and logic are absent.
//
// Parameters:
//   DEPTH   FIFO entries, power of two, >= 2
//   DATA_W  AES block width
//   LVL_W   width of the occupancy count ($clog2(DEPTH)+1)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   eng_out       in   engine result block
//   eng_out_type  in   engine job type (0 INVALID, 1 ENCRYPT, 2 DECRYPT)
//   halt          out  freezes the engine pipeline when high (registered)
//   flush         in   synchronous clear of the buffer
//   res_valid     out  head entry available
//   res_ready     in   downstream accepts the head entry
//   res_data      out  head entry result block (registered head view)
//   res_type      out  head entry job type (ENCRYPT or DECRYPT)
//   level         out  current occupancy, 0..DEPTH
//   enc_cnt       out  accepted ENCRYPT results (AES_COLLECT_STATS_EN only)
//   dec_cnt       out  accepted DECRYPT results (AES_COLLECT_STATS_EN only)
// -----------------------------------------------------------------------------
module aes_result_collector #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] eng_out,
    input  logic [1:0]        eng_out_type,
    output logic              halt,
    input  logic              flush,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [1:0]        res_type,
    output logic [LVL_W-1:0]  level
`ifdef AES_COLLECT_STATS_EN
    ,
    output logic [31:0]       enc_cnt,
    output logic [31:0]       dec_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Job encodings as produced by the engine.
    localparam logic [1:0] JOB_INVALID = 2'd0;
    localparam logic [1:0] JOB_ENCRYPT = 2'd1;
    localparam logic [1:0] JOB_DECRYPT = 2'd2;

    // Each storage word carries the job type above the result block.
    logic [DATA_W+1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;

    logic              is_job;
    logic              push;
    logic              pop;
    logic              head_load;
    logic [DATA_W+1:0] head_d;

    assign is_job = (eng_out_type == JOB_ENCRYPT) || (eng_out_type == JOB_DECRYPT);

    // While halted the engine holds its output, so sampling would duplicate it.
    assign push = is_job && !halt && !flush;
    assign pop  = res_valid && res_ready && !flush;

    assign level = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Read-ahead head view: the next head is either the word being written
    // this cycle (it lands exactly at the new head slot, i.e. the FIFO was
    // empty after any pop) or the word already stored at the new read pointer.
    // When the FIFO drains the head registers simply hold their last value.
    always_comb begin
        head_load = !flush && (count_d != '0);
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = {eng_out_type, eng_out};
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {eng_out_type, eng_out};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            halt      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_type  <= JOB_INVALID;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            // Overflow is impossible: push is gated by this same register.
            halt      <= (count_d == FULL_LVL);
            res_valid <= (count_d != '0);
            if (head_load) begin
                res_data <= head_d[DATA_W-1:0];
                res_type <= head_d[DATA_W+1:DATA_W];
            end
        end
    end

`ifdef AES_COLLECT_STATS_EN
    // Saturating per-type counters; flush does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_cnt <= '0;
            dec_cnt <= '0;
        end else begin
            if (push && (eng_out_type == JOB_ENCRYPT) && (enc_cnt != 32'hFFFF_FFFF)) begin
                enc_cnt <= enc_cnt + 32'd1;
            end
            if (push && (eng_out_type == JOB_DECRYPT) && (dec_cnt != 32'hFFFF_FFFF)) begin
                dec_cnt <= dec_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/aes_result_collector.md
Name: aes_result_collector

Overview:
- Consumer end of the aes_engine output interface. Each cycle the engine is not halted, it samples `out`/`out_type`.
- Completed ENCRYPT/DECRYPT results are buffered in a FIFO and presented downstream on a valid/ready handshake.
- Drives the engine's `halt` input as backpressure, so no result is ever lost or duplicated.
- Sits between aes_engine and the host/DMA read path.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- DATA_W, 128, AES block width.
- LVL_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- eng_out  input  DATA_W  aes_engine `out`.
- eng_out_type  input  2  aes_engine `out_type` (job_t from sysdef.svh: INVALID/ENCRYPT/DECRYPT).
- halt  output  1  to aes_engine `halt`; freezes the engine pipeline when high.
- flush  input  1  synchronous clear of the buffer.
- res_valid  output  1  head entry available.
- res_ready  input  1  downstream accepts the head entry.
- res_data  output  DATA_W  head entry result block.
- res_type  output  2  head entry job_t (ENCRYPT or DECRYPT only).
- level  output  LVL_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst=1): count=0, rd/wr pointers=0, halt=0, res_valid=0, res_data=0, res_type=INVALID, level=0. Storage array is not reset.
- push = (eng_out_type==ENCRYPT || eng_out_type==DECRYPT) && !halt && !flush. INVALID and any other encoding is never stored.
- pop = res_valid && res_ready && !flush.
- Rationale for gating push by halt: while halt=1 the engine holds `out`, so sampling would duplicate the entry.
- halt is a register: next value = (count_next == DEPTH). Asserts the cycle after the FIFO becomes full. It deasserts the cycle after the first pop from full.
- Full guarantee: push is gated by the same registered halt, so overflow is impossible. When count==DEPTH, halt==1 and no push occurs.
- Storage is a circular buffer. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
- count updates by +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a result pushed at edge N is visible with res_valid=1 after edge N (first-word latency 1 cycle). res_data/res_type are a registered head view (read-ahead), not a combinational memory read.
- Push and pop in the same cycle at count==1: head advances to the new entry, res_valid stays 1, count stays 1.
- Empty: res_valid=0, and res_data/res_type hold their last value. Downstream must qualify with res_valid.
- res_data/res_type must not change while res_valid=1 && res_ready=0.
- flush=1: next cycle count=0, pointers=0, res_valid=0, halt=0. A same-cycle engine output is discarded. flush overrides push and pop.
- Reset asserted mid-transfer: all state cleared immediately, with no handshake completion.
- level equals count (registered).

Optional Feature:
- Macro: AES_COLLECT_STATS_EN.
- When defined, adds outputs enc_cnt (output, 32) and dec_cnt (output, 32).
- Each counter increments on every push of its type and saturates at 32'hFFFF_FFFF.
- Counters are reset by rst and are not affected by flush.
- When undefined, these ports and their logic are absent, and the block behaves identically otherwise.

Test Plan:
- Single result: after reset, drive eng_out=128'h69c4e0d86a7b0430d8cdb78070b4c55a, type=ENCRYPT for 1 cycle, res_ready=1 -> one cycle later res_valid=1, res_data=69c4…c55a, res_type=ENCRYPT; next cycle res_valid=0, level=0.
- INVALID filtering: 5 cycles of eng_out_type=INVALID with arbitrary data -> res_valid stays 0, level=0, halt=0.
- Fill/backpressure: res_ready=0, push 8 DECRYPT results with data 1..8 -> level=8, halt=1 the cycle after the 8th push. Extra inputs during halt are not stored. Then res_ready=1 -> drains 1..8 in order, halt drops after the first pop.
- Simultaneous push/pop: level=1, res_ready=1, push ENCRYPT data A each cycle for 10 cycles -> level stays 1 and outputs appear in order with no gaps.
- Flush: level=5, assert flush with a same-cycle ENCRYPT push -> next cycle level=0, res_valid=0, halt=0; the pushed word never appears.
- Reset mid-operation: level=3, res_valid=1, assert rst asynchronously between edges -> res_valid, halt and level go to 0 immediately. With AES_COLLECT_STATS_EN, enc_cnt=dec_cnt=0.
